// File: rtl/fetch_unit_rv32.sv
// fetch_unit_rv32: RV32I instruction fetch stage.
// Owns the PC and drives it to the instruction cache. Each word the cache returns is
// stored with its PC in a prefetch FIFO. Decode reads the FIFO head through a
// valid/ready handshake. A redirect from execute flushes the FIFO and reloads the PC.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target parks the unit in TRAP. When it is not defined, the target is
// word-aligned on load.
module fetch_unit_rv32 #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic [31:0] oPCADDR,
    input  logic [31:0] iPCDATA,
    input  logic        iStallI,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic        oInstrValid,
    input  logic        iDecReady,
    output logic [31:0] oInstr,
    output logic [31:0] oInstrPC,
    output logic        oMisalign
);
    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_TRAP  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      instr_mem_q [FIFO_DEPTH];
    logic [31:0]      pc_mem_q    [FIFO_DEPTH];

    logic        fifo_full_s, fifo_empty_s;
    logic        flush_s, push_s, pop_s, valid_s;
    logic [31:0] redirect_pc_s;

    assign fifo_full_s  = (count_q == DEPTH_C);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});

`ifdef FETCH_MISALIGN_TRAP_EN
    logic target_misaligned_s;
    assign target_misaligned_s = (iRedirectPC[1:0] != 2'b00);
    assign redirect_pc_s       = iRedirectPC;
`else
    assign redirect_pc_s       = iRedirectPC & 32'hFFFF_FFFC;
`endif

    // State register: BOOT after reset, then FETCH (or TRAP).
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT always lasts one cycle; only a redirect can change FETCH/TRAP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH, ST_TRAP: begin
                if (iRedirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (target_misaligned_s) begin
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_FETCH;
                    end
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Outputs and FIFO controls per state. A redirect wins over both push and pop.
    // Full blocks push regardless of pop, so iDecReady never reaches the cache side.
    always_comb begin
        flush_s   = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        valid_s   = 1'b0;
        oMisalign = 1'b0;
        case (state_q)
            ST_BOOT: begin
                flush_s = 1'b0;
            end
            ST_FETCH: begin
                flush_s = iRedirect;
                push_s  = ~iRedirect & ~iStallI & ~fifo_full_s;
                pop_s   = ~iRedirect & ~fifo_empty_s & iDecReady;
                valid_s = ~fifo_empty_s;
            end
            ST_TRAP: begin
                flush_s = iRedirect;
`ifdef FETCH_MISALIGN_TRAP_EN
                oMisalign = 1'b1;
`else
                oMisalign = 1'b0;
`endif
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase

        if (flush_s) begin
            pc_d = redirect_pc_s;
        end else if (push_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and prefetch FIFO storage, pointers and occupancy.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= 32'h0000_0000;
            end
        end else begin
            pc_q <= pc_d;
            if (flush_s) begin
                wr_ptr_q <= {PTR_W{1'b0}};
                rd_ptr_q <= {PTR_W{1'b0}};
                count_q  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    instr_mem_q[wr_ptr_q] <= iPCDATA;
                    pc_mem_q[wr_ptr_q]    <= pc_q;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign oPCADDR     = pc_q;
    assign oInstrValid = valid_s;
    assign oInstr      = instr_mem_q[rd_ptr_q];
    assign oInstrPC    = pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_unit_rv32.sv
// Testbench for fetch_unit_rv32. It uses a directed vector table, hand-written corner
// sequences and randomized traffic. Every cycle is checked against a queue-based
// reference model.
`timescale 1ns/1ps
module tb_fetch_unit_rv32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk, rst_n;
    logic [31:0] pcaddr, pcdata, rpcv, instr, ipc;
    logic        stall, redir, valid, dec_ready, misalign;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit_rv32 #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .iCLK(clk), .iRST(rst_n), .oPCADDR(pcaddr), .iPCDATA(pcdata),
        .iStallI(stall), .iRedirect(redir), .iRedirectPC(rpcv),
        .oInstrValid(valid), .iDecReady(dec_ready), .oInstr(instr),
        .oInstrPC(ipc), .oMisalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents seen by the cache: a distinct word per address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
    endfunction
    assign pcdata = word_of(pcaddr);

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_boot, m_trap;

    function automatic void model_reset();
        m_q.delete();
        m_pc   = RST_PC;
        m_boot = 1'b1;
        m_trap = 1'b0;
    endfunction

    function automatic void model_step(input bit st, input bit rd, input logic [31:0] rpc, input bit ready);
        bit full;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (rd) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc   = rpc;
            m_trap = (rpc % 4) != 0;
`else
            m_pc   = rpc - (rpc % 4);
            m_trap = 1'b0;
`endif
        end else if (!m_trap) begin
            full = (m_q.size() == DEPTH);
            if (m_q.size() != 0 && ready) void'(m_q.pop_front());
            if (!st && !full) begin
                m_q.push_back('{m_pc, word_of(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit mv;
        mv = (m_q.size() != 0) && !m_trap;
        chk("m_pcaddr", pcaddr, m_pc);
        chk("m_valid", 32'(valid), 32'(mv));
        chk("m_misalign", 32'(misalign), 32'(m_trap));
        if (mv) begin
            chk("m_instr_pc", ipc, m_q[0].pc);
            chk("m_instr", instr, m_q[0].w);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and check just after the edge.
    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit ready);
        stall = st; redir = rd; rpcv = rpc; dec_ready = ready;
        model_step(st, rd, rpc, ready);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pcaddr"}, pcaddr, RST_PC);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_instr_pc"}, ipc, 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpcv = 32'd0; dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit st; bit rd; logic [31:0] rpc; bit rdy;
        bit ev; logic [31:0] eipc; logic [31:0] epa; bit em;
    } vec_t;
    vec_t tbl[19];

    initial begin
        logic [31:0] r;
        int          sel;

        // st rd rpc rdy | ev eipc epa em
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h100, 1'b0}; // BOOT: no capture
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h104, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 32'h108, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 32'h10C, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h10C, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h10C, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h110, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h114, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h118, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h11C, 1'b0}; // now full
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h11C, 1'b0}; // full: hold
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 32'h11C, 1'b0}; // full blocks push despite pop
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h114, 32'h120, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0,   32'h400, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 32'h404, 1'b0};
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl[15] = '{1'b0, 1'b1, 32'h402, 1'b0, 1'b0, 32'h0,   32'h402, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h402, 1'b1};
`else
        tbl[15] = '{1'b0, 1'b1, 32'h402, 1'b0, 1'b0, 32'h0,   32'h400, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'h404, 1'b0};
`endif
        tbl[17] = '{1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0,   32'h500, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h500, 32'h504, 1'b0};

        do_reset();
        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("tbl%0d_pcaddr", i), pcaddr, tbl[i].epa);
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_misalign", i), 32'(misalign), 32'(tbl[i].em));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_instr_pc", i), ipc, tbl[i].eipc);
                chk($sformatf("tbl%0d_instr", i), instr, word_of(tbl[i].eipc));
            end
        end

        // Stall for 5 cycles at 0x200: PC holds and nothing is queued.
        cycle(1'b0, 1'b1, 32'h200, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            chk("stall_pcaddr", pcaddr, 32'h200);
            chk("stall_valid", 32'(valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stall_release_valid", 32'(valid), 32'd1);
        chk("stall_release_pc", ipc, 32'h200);

        // Redirect with 3 entries queued and a pop requested in the same cycle.
        cycle(1'b0, 1'b1, 32'h300, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h400, 1'b1);
        chk("redir_valid", 32'(valid), 32'd0);
        chk("redir_pcaddr", pcaddr, 32'h400);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_first_pc", ipc, 32'h400);

        // PC wraps modulo 2^32.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pcaddr", pcaddr, 32'h0000_0000);
        chk("wrap_pc", ipc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_next_pc", ipc, 32'h0000_0000);

        // Asynchronous reset in the middle of a cycle while entries are queued.
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic checked against the reference model.
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom();
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            end else if (sel != 1) begin
                r[1:0] = 2'b00;
            end
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, r,
                  $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit_rv32.md
# fetch_unit_rv32

Instruction fetch stage of the RV32I core, sitting directly upstream of the instruction cache. Owns the program counter, drives the fetch address into the cache, captures each returned instruction word with its PC into a small prefetch FIFO, and presents them to decode through a valid/ready handshake. Honours cache stalls and flushes on branch/jump redirects from execute.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- FIFO_DEPTH, 4, prefetch entries; power of two, 2..16
- iCLK  input  1  clock, rising edge
- iRST  input  1  reset, asynchronous, active-low
- oPCADDR  output  32  fetch address to the instruction cache
- iPCDATA  input  32  instruction word from the cache for oPCADDR
- iStallI  input  1  cache has no data for oPCADDR this cycle
- iRedirect  input  1  taken branch/jump/trap from execute
- iRedirectPC  input  32  redirect target
- oInstrValid  output  1  FIFO head valid
- iDecReady  input  1  decode accepts head this cycle
- oInstr  output  32  head instruction word
- oInstrPC  output  32  head instruction PC
- oMisalign  output  1  misaligned redirect target (see Configuration)

## Operation
- FSM states: BOOT, FETCH, TRAP (TRAP only with macro).
- Reset (iRST=0): state BOOT, oPCADDR=RESET_PC, FIFO empty, pointers/count 0, oInstrValid=0, oInstr=0, oInstrPC=0, oMisalign=0.
- BOOT: lasts exactly one cycle after reset release; no capture; -> FETCH.
- FETCH, per cycle, in priority order:
  - iRedirect=1: flush FIFO (count 0, pointers 0), oPCADDR<=iRedirectPC, discard iPCDATA, ignore pop.
  - iStallI=0 and FIFO not full: push {oPCADDR, iPCDATA}; oPCADDR<=oPCADDR+4.
  - iStallI=1 or FIFO full: hold oPCADDR, no push.
- Full blocks push even if a pop occurs the same cycle (no combinational path from iDecReady to cache).
- Pop: oInstrValid & iDecReady & ~iRedirect; head advances.
- Push and pop same cycle (not full, not empty): count unchanged, both pointers advance.
- oInstrValid = (count != 0); oInstr/oInstrPC = head entry (first-word fall-through, driven from FIFO storage, not from iPCDATA).
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- oPCADDR may change while iStallI=1 (redirect); the cache abandons the old miss.

## Timing
- Cache contract: iPCDATA is valid for the current oPCADDR in any cycle with iStallI=0.
- Hit in cycle N -> oInstrValid=1 with that word in N+1 (if FIFO was empty).
- Redirect in cycle N -> oPCADDR=target and oInstrValid=0 in N+1; earliest target instruction at decode in N+2.
- Sustained throughput: one instruction per cycle with continuous hits and iDecReady=1.
- Reset assertion mid-operation: all state returns to reset values immediately (asynchronous), regardless of FIFO contents or pending miss.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with iRedirectPC[1:0]!=0 flushes FIFO, loads oPCADDR<=iRedirectPC, enters TRAP. TRAP: oMisalign=1, no pushes, oInstrValid=0; leaves only on a redirect with aligned target (-> FETCH, oMisalign=0 next cycle); misaligned redirect stays in TRAP.
- Not defined: iRedirectPC[1:0] forced to 2'b00 on load, no TRAP state, oMisalign tied 0.

## Test plan
- Reset release, RESET_PC=0x100, iStallI=0, iDecReady=1 -> BOOT 1 cycle, then oInstrPC 0x100,0x104,0x108 on consecutive cycles, one per cycle.
- iDecReady=0, continuous hits, FIFO_DEPTH=4 -> 4 pushes, oPCADDR holds at base+0x10, then iDecReady=1 drains 0x0..0xC in order with no duplicates or gaps.
- iStallI=1 for 5 cycles at 0x200 -> oPCADDR held 0x200, no push; on iStallI=0 word at 0x200 appears next cycle.
- Redirect to 0x400 with 3 entries queued and pop same cycle -> next cycle oInstrValid=0, oPCADDR=0x400; first delivered PC is 0x400.
- PC at 0xFFFF_FFFC, hit -> oPCADDR becomes 0x0000_0000.
- Macro on: redirect to 0x402 -> oMisalign=1, no fetch; redirect to 0x500 -> oMisalign=0, fetch resumes at 0x500. Macro off: redirect to 0x402 -> oPCADDR=0x400.
